// File: rtl/down_timer_if.sv
// Control/status bundle for down_timer: master drives load/set/start/pause,
// slave (the timer) drives q/tick/done/busy.
interface down_timer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] set;
    logic             start;
    logic             pause;
    logic [WIDTH-1:0] q;
    logic             tick;
    logic             done;
    logic             busy;

    modport master (
        output load, set, start, pause,
        input  q, tick, done, busy
    );

    modport slave (
        input  load, set, start, pause,
        output q, tick, done, busy
    );
endinterface

// File: rtl/down_timer.sv
// Prescaled down-counter with IDLE/RUN/PAUSED/DONE control and registered outputs.
// Define DOWN_TIMER_AUTO_RELOAD_EN to restart from the last loaded value on expiry.
module down_timer #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned CLK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    down_timer_if.slave io_tmr
);
    localparam int unsigned   PW         = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_t;

    state_t           r_state;
    logic [PW-1:0]    r_presc;
    logic [WIDTH-1:0] r_q;
    logic             r_tick;
    logic             r_done;
    logic             r_busy;

    logic             w_wrap;
    logic             w_last;
    logic             w_reload;
    logic [WIDTH-1:0] w_reload_val;

    assign w_wrap = (r_presc == PRESC_LAST);
    assign w_last = (r_q == WIDTH'(1));

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] r_reload;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_reload <= '0;
        end else if (io_tmr.load) begin
            r_reload <= io_tmr.set;
        end
    end

    // A zero reload value falls back to the one-shot expiry path.
    assign w_reload     = (r_reload != '0);
    assign w_reload_val = r_reload;
`else
    assign w_reload     = 1'b0;
    assign w_reload_val = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_presc <= '0;
            r_q     <= '0;
            r_tick  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (io_tmr.load) begin
                r_state <= StIdle;
                r_presc <= '0;
                r_q     <= io_tmr.set;
                r_done  <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (io_tmr.start) begin
                            if (r_q != '0) begin
                                r_state <= StRun;
                                r_presc <= '0;
                                r_busy  <= 1'b1;
                            end else begin
                                r_state <= StDone;
                                r_done  <= 1'b1;
                            end
                        end
                    end

                    StRun: begin
                        r_done <= 1'b0;
                        if (io_tmr.pause) begin
                            // The pausing cycle still counts, but a due wrap is held
                            // back so the step fires on the first cycle after resume.
                            r_state <= StPaused;
                            if (!w_wrap) begin
                                r_presc <= r_presc + 1'b1;
                            end
                        end else if (w_wrap) begin
                            r_presc <= '0;
                            r_tick  <= 1'b1;
                            if (w_last) begin
                                r_done <= 1'b1;
                                if (w_reload) begin
                                    r_q <= w_reload_val;
                                end else begin
                                    r_q     <= '0;
                                    r_state <= StDone;
                                    r_busy  <= 1'b0;
                                end
                            end else begin
                                r_q <= r_q - 1'b1;
                            end
                        end else begin
                            r_presc <= r_presc + 1'b1;
                        end
                    end

                    StPaused: begin
                        if (io_tmr.start) begin
                            r_state <= StRun;
                        end
                    end

                    StDone: begin
                        r_q <= '0;
                    end

                    default: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign io_tmr.q    = r_q;
    assign io_tmr.tick = r_tick;
    assign io_tmr.done = r_done;
    assign io_tmr.busy = r_busy;
endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer with WIDTH=4, CLK_DIV=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_down_timer;
    localparam int unsigned W  = 4;
    localparam int unsigned CD = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    down_timer_if #(.WIDTH(W)) u_if ();

    down_timer #(
        .WIDTH  (W),
        .CLK_DIV(CD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io_tmr(u_if)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        u_if.load  = 1'b0;
        u_if.start = 1'b0;
        u_if.pause = 1'b0;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        u_if.load = 1'b1;
        u_if.set  = v;
        cyc();
        u_if.load = 1'b0;
    endtask

    task automatic do_start();
        u_if.start = 1'b1;
        cyc();
        u_if.start = 1'b0;
    endtask

    task automatic test_reset();
        // Reset must override load and start asserted on the same edge.
        reset      = 1'b1;
        u_if.load  = 1'b1;
        u_if.set   = 4'd9;
        u_if.start = 1'b1;
        cyc();
        reset = 1'b0;
        idle_inputs();
        n_vec++;
        if ({u_if.q, u_if.tick, u_if.done, u_if.busy} !== {4'd0, 3'b000}) begin
            n_err++;
            $display("FAIL reset_state: got q=%0d tick=%b done=%b busy=%b want q=0 tick=0 done=0 busy=0",
                     u_if.q, u_if.tick, u_if.done, u_if.busy);
        end
        repeat (3) cyc();
        n_vec++;
        if ({u_if.q, u_if.tick, u_if.done, u_if.busy} !== {4'd0, 3'b000}) begin
            n_err++;
            $display("FAIL reset_hold: got q=%0d tick=%b done=%b busy=%b want q=0 tick=0 done=0 busy=0",
                     u_if.q, u_if.tick, u_if.done, u_if.busy);
        end
    endtask

    task automatic test_countdown();
        logic [W-1:0] eq;
        logic et, ed, eb;
        do_load(4'd3);
        n_vec++;
        if ({u_if.q, u_if.done, u_if.busy} !== {4'd3, 2'b00}) begin
            n_err++;
            $display("FAIL cnt_load: got q=%0d done=%b busy=%b want q=3 done=0 busy=0",
                     u_if.q, u_if.done, u_if.busy);
        end
        do_start();
        n_vec++;
        if ({u_if.q, u_if.tick, u_if.busy} !== {4'd3, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL cnt_start: got q=%0d tick=%b busy=%b want q=3 tick=0 busy=1",
                     u_if.q, u_if.tick, u_if.busy);
        end
        for (int k = 1; k <= 12; k++) begin
            cyc();
            eq = 4'(3 - k / 4);
            et = (k % 4 == 0);
            ed = (k == 12);
            eb = (k < 12);
            n_vec++;
            if ({u_if.q, u_if.tick, u_if.done, u_if.busy} !== {eq, et, ed, eb}) begin
                n_err++;
                $display("FAIL cnt_run k=%0d: got q=%0d tick=%b done=%b busy=%b want q=%0d tick=%b done=%b busy=%b",
                         k, u_if.q, u_if.tick, u_if.done, u_if.busy, eq, et, ed, eb);
            end
        end
        // Expired: q holds 0 and done stays high; start/pause are ignored.
        for (int k = 1; k <= 20; k++) begin
            u_if.start = (k % 3 == 0);
            u_if.pause = (k % 5 == 0);
            cyc();
            n_vec++;
            if ({u_if.q, u_if.tick, u_if.done, u_if.busy} !== {4'd0, 3'b010}) begin
                n_err++;
                $display("FAIL cnt_done k=%0d: got q=%0d tick=%b done=%b busy=%b want q=0 tick=0 done=1 busy=0",
                         k, u_if.q, u_if.tick, u_if.done, u_if.busy);
            end
        end
        idle_inputs();
    endtask

    task automatic test_pause();
        logic [W-1:0] eq;
        logic et;
        do_load(4'd5);
        do_start();
        for (int k = 1; k <= 22; k++) begin
            u_if.pause = (k >= 6 && k <= 15);
            u_if.start = (k == 16);
            cyc();
            eq = (k < 4) ? 4'd5 : (k < 18) ? 4'd4 : (k < 22) ? 4'd3 : 4'd2;
            et = (k == 4 || k == 18 || k == 22);
            n_vec++;
            if ({u_if.q, u_if.tick, u_if.done, u_if.busy} !== {eq, et, 2'b01}) begin
                n_err++;
                $display("FAIL pause k=%0d: got q=%0d tick=%b done=%b busy=%b want q=%0d tick=%b done=0 busy=1",
                         k, u_if.q, u_if.tick, u_if.done, u_if.busy, eq, et);
            end
        end
        idle_inputs();
    endtask

    task automatic test_pause_on_wrap();
        logic [W-1:0] eq;
        logic et;
        do_load(4'd5);
        do_start();
        for (int k = 1; k <= 9; k++) begin
            u_if.pause = (k == 4 || k == 6);
            u_if.start = (k == 8);
            cyc();
            eq = (k < 9) ? 4'd5 : 4'd4;
            et = (k == 9);
            n_vec++;
            if ({u_if.q, u_if.tick, u_if.busy} !== {eq, et, 1'b1}) begin
                n_err++;
                $display("FAIL pause_wrap k=%0d: got q=%0d tick=%b busy=%b want q=%0d tick=%b busy=1",
                         k, u_if.q, u_if.tick, u_if.busy, eq, et);
            end
        end
        idle_inputs();
    endtask

    task automatic test_start_pause_together();
        logic [W-1:0] eq;
        logic et;
        do_load(4'd5);
        u_if.start = 1'b1;
        u_if.pause = 1'b1;
        cyc();
        idle_inputs();
        n_vec++;
        if ({u_if.q, u_if.tick, u_if.busy} !== {4'd5, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL sp_idle: got q=%0d tick=%b busy=%b want q=5 tick=0 busy=1",
                     u_if.q, u_if.tick, u_if.busy);
        end
        for (int k = 1; k <= 7; k++) begin
            u_if.start = (k == 2 || k == 5);
            u_if.pause = (k == 2 || k == 5);
            cyc();
            eq = (k < 7) ? 4'd5 : 4'd4;
            et = (k == 7);
            n_vec++;
            if ({u_if.q, u_if.tick, u_if.busy} !== {eq, et, 1'b1}) begin
                n_err++;
                $display("FAIL sp_both k=%0d: got q=%0d tick=%b busy=%b want q=%0d tick=%b busy=1",
                         k, u_if.q, u_if.tick, u_if.busy, eq, et);
            end
        end
        idle_inputs();
    endtask

    task automatic test_load_on_wrap();
        logic [W-1:0] eq;
        logic et, eb;
        do_load(4'd3);
        do_start();
        for (int k = 1; k <= 8; k++) begin
            u_if.load = (k == 8);
            u_if.set  = 4'd9;
            cyc();
            eq = (k == 8) ? 4'd9 : (k < 4) ? 4'd3 : 4'd2;
            et = (k == 4);
            eb = (k < 8);
            n_vec++;
            if ({u_if.q, u_if.tick, u_if.done, u_if.busy} !== {eq, et, 1'b0, eb}) begin
                n_err++;
                $display("FAIL load_wrap k=%0d: got q=%0d tick=%b done=%b busy=%b want q=%0d tick=%b done=0 busy=%b",
                         k, u_if.q, u_if.tick, u_if.done, u_if.busy, eq, et, eb);
            end
        end
        idle_inputs();
        repeat (5) cyc();
        n_vec++;
        if ({u_if.q, u_if.tick, u_if.done, u_if.busy} !== {4'd9, 3'b000}) begin
            n_err++;
            $display("FAIL load_idle_hold: got q=%0d tick=%b done=%b busy=%b want q=9 tick=0 done=0 busy=0",
                     u_if.q, u_if.tick, u_if.done, u_if.busy);
        end
    endtask

    task automatic test_zero_start();
        do_load(4'd0);
        do_start();
        n_vec++;
        if ({u_if.q, u_if.tick, u_if.done, u_if.busy} !== {4'd0, 3'b010}) begin
            n_err++;
            $display("FAIL zero_start: got q=%0d tick=%b done=%b busy=%b want q=0 tick=0 done=1 busy=0",
                     u_if.q, u_if.tick, u_if.done, u_if.busy);
        end
        for (int k = 1; k <= 6; k++) begin
            u_if.start = k[0];
            u_if.pause = ~k[0];
            cyc();
            n_vec++;
            if ({u_if.q, u_if.tick, u_if.done, u_if.busy} !== {4'd0, 3'b010}) begin
                n_err++;
                $display("FAIL zero_hold k=%0d: got q=%0d tick=%b done=%b busy=%b want q=0 tick=0 done=1 busy=0",
                         k, u_if.q, u_if.tick, u_if.done, u_if.busy);
            end
        end
        idle_inputs();
        do_load(4'd2);
        n_vec++;
        if ({u_if.q, u_if.done, u_if.busy} !== {4'd2, 2'b00}) begin
            n_err++;
            $display("FAIL load_clears_done: got q=%0d done=%b busy=%b want q=2 done=0 busy=0",
                     u_if.q, u_if.done, u_if.busy);
        end
    endtask

    task automatic test_reset_mid();
        do_load(4'd7);
        do_start();
        repeat (3) cyc();
        // Reset lands on the wrap edge with every other input asserted.
        reset      = 1'b1;
        u_if.load  = 1'b1;
        u_if.set   = 4'd5;
        u_if.start = 1'b1;
        cyc();
        reset = 1'b0;
        idle_inputs();
        n_vec++;
        if ({u_if.q, u_if.tick, u_if.done, u_if.busy} !== {4'd0, 3'b000}) begin
            n_err++;
            $display("FAIL reset_run: got q=%0d tick=%b done=%b busy=%b want q=0 tick=0 done=0 busy=0",
                     u_if.q, u_if.tick, u_if.done, u_if.busy);
        end
        do_start();
        n_vec++;
        if ({u_if.q, u_if.tick, u_if.done, u_if.busy} !== {4'd0, 3'b010}) begin
            n_err++;
            $display("FAIL reset_then_start: got q=%0d tick=%b done=%b busy=%b want q=0 tick=0 done=1 busy=0",
                     u_if.q, u_if.tick, u_if.done, u_if.busy);
        end
        do_load(4'd6);
        do_start();
        cyc();
        u_if.pause = 1'b1;
        cyc();
        u_if.pause = 1'b0;
        reset      = 1'b1;
        cyc();
        reset = 1'b0;
        n_vec++;
        if ({u_if.q, u_if.tick, u_if.done, u_if.busy} !== {4'd0, 3'b000}) begin
            n_err++;
            $display("FAIL reset_paused: got q=%0d tick=%b done=%b busy=%b want q=0 tick=0 done=0 busy=0",
                     u_if.q, u_if.tick, u_if.done, u_if.busy);
        end
        repeat (2) cyc();
        n_vec++;
        if ({u_if.q, u_if.busy} !== {4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_paused_hold: got q=%0d busy=%b want q=0 busy=0", u_if.q, u_if.busy);
        end
    endtask

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    task automatic test_auto_reload();
        logic [W-1:0] eq;
        logic et, ed;
        do_load(4'd2);
        do_start();
        for (int k = 1; k <= 24; k++) begin
            cyc();
            eq = (k < 4) ? 4'd2 : (((k / 4) % 2) == 1) ? 4'd1 : 4'd2;
            et = (k % 4 == 0);
            ed = (k % 8 == 0);
            n_vec++;
            if ({u_if.q, u_if.tick, u_if.done, u_if.busy} !== {eq, et, ed, 1'b1}) begin
                n_err++;
                $display("FAIL auto_reload k=%0d: got q=%0d tick=%b done=%b busy=%b want q=%0d tick=%b done=%b busy=1",
                         k, u_if.q, u_if.tick, u_if.done, u_if.busy, eq, et, ed);
            end
        end
    endtask
`endif

    initial begin
        idle_inputs();
        u_if.set = '0;
        reset    = 1'b1;
        cyc();
        cyc();
        test_reset();
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        test_auto_reload();
`else
        test_countdown();
`endif
        test_pause();
        test_pause_on_wrap();
        test_start_pause_together();
        test_load_on_wrap();
        test_zero_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
